// File: rtl/hdmi_read_scheduler_if.sv
// Burst read request channel between hdmi_read_scheduler (master) and the bus read master (slave).
interface hdmi_read_scheduler_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_len;
  logic              rd_ack;
  logic              rd_cmplt;

  modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_cmplt);
  modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_cmplt);
endinterface

// File: rtl/hdmi_read_scheduler.sv
// Frame-buffer read sequencer: turns hdmi_core pulses into single-outstanding burst requests.
// Optional rd_ack->rd_cmplt watchdog enabled by defining HDMI_RD_TIMEOUT_EN.
module hdmi_read_scheduler #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned CHUNK_BYTES    = 256,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     frame_base,
  input  logic [10:0]           hres,
  input  logic [10:0]           vres,
  input  logic [1:0]            num_bytes_per_pixel,
  input  logic                  read_go,
  input  logic                  read_next_line,
  input  logic                  read_next_chunk,
  output logic                  read_done,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout_err,
  hdmi_read_scheduler_if.master rd
);

  if (CHUNK_BYTES < 16 || CHUNK_BYTES > 4096 || (CHUNK_BYTES & (CHUNK_BYTES - 1)) != 0 ||
      TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("hdmi_read_scheduler: invalid CHUNK_BYTES or TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_CMPLT, S_ARMED
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [10:0]       r_vres, r_line;
  logic [12:0]       r_line_bytes, r_rem;
  logic [ADDR_W-1:0] r_line_addr, r_chunk_addr, r_rd_addr;
  logic [15:0]       r_rd_len;
  logic              r_pend_line, r_pend_chunk, r_done, r_overrun;

  logic [12:0] w_line_bytes, w_chunk_len;
  logic        w_go, w_zero, w_last_line, w_line_empty_after, w_frame_end;
  logic        w_pend_any, w_eff_line, w_eff_chunk, w_adv_line, w_adv_chunk;
  logic        w_cmplt, w_tmo, w_pulse, w_in_burst;

  always_comb begin
    unique case (num_bytes_per_pixel)
      2'd0:    w_line_bytes = {2'b00, hres};
      2'd1:    w_line_bytes = {1'b0, hres, 1'b0};
      default: w_line_bytes = {hres, 2'b00};
    endcase
  end

  // r_rem counts bytes still unread in the current line, so the last chunk length falls out of min()
  assign w_chunk_len        = (r_rem > 13'(CHUNK_BYTES)) ? 13'(CHUNK_BYTES) : r_rem;
  assign w_go               = (r_state == S_IDLE) & start & read_go;
  assign w_zero             = (hres == '0) | (vres == '0);
  assign w_last_line        = (r_line == r_vres - 11'd1);
  assign w_line_empty_after = (r_rem == r_rd_len[12:0]);
  assign w_frame_end        = w_last_line & w_line_empty_after;
  assign w_cmplt            = (r_state == S_WAIT_CMPLT) & rd.rd_cmplt;
  assign w_pulse            = read_next_line | read_next_chunk;
  assign w_in_burst         = (r_state == S_ISSUE) | (r_state == S_WAIT_ACK) |
                              (r_state == S_WAIT_CMPLT);

  // A latched pulse takes precedence over a live one in ARMED; the live one is re-latched
  assign w_pend_any  = r_pend_line | r_pend_chunk;
  assign w_eff_line  = w_pend_any ? r_pend_line  : read_next_line;
  assign w_eff_chunk = w_pend_any ? r_pend_chunk : (read_next_chunk & ~read_next_line);
  assign w_adv_line  = (r_state == S_ARMED) & start & w_eff_line & ~w_last_line;
  assign w_adv_chunk = (r_state == S_ARMED) & start & w_eff_chunk & (r_rem != '0);

`ifdef HDMI_RD_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] r_wd;
  logic            r_timeout;

  always_ff @(posedge clock) begin
    if (reset || r_state != S_WAIT_CMPLT) r_wd <= '0;
    else                                  r_wd <= r_wd + 1'b1;
  end

  assign w_tmo = (r_state == S_WAIT_CMPLT) & ~rd.rd_cmplt & (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset)      r_timeout <= 1'b0;
    else if (w_go)  r_timeout <= 1'b0;
    else if (w_tmo) r_timeout <= 1'b1;
  end

  assign timeout_err = r_timeout;
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:       if (w_go && !w_zero) w_state_nxt = S_ISSUE;
      S_ISSUE:      w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK:   if (rd.rd_ack) w_state_nxt = S_WAIT_CMPLT;
      S_WAIT_CMPLT: begin
        if (rd.rd_cmplt) w_state_nxt = (start && !w_frame_end) ? S_ARMED : S_IDLE;
        else if (w_tmo)  w_state_nxt = S_IDLE;
      end
      S_ARMED: begin
        if (!start)                       w_state_nxt = S_IDLE;
        else if (w_adv_line || w_adv_chunk) w_state_nxt = S_ISSUE;
      end
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd.rd_req = (r_state == S_WAIT_ACK);
    busy      = (r_state != S_IDLE);
  end

  assign rd.rd_addr = r_rd_addr;
  assign rd.rd_len  = r_rd_len;
  assign read_done  = r_done;
  assign overrun    = r_overrun;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vres       <= '0;
      r_line       <= '0;
      r_line_bytes <= '0;
      r_rem        <= '0;
      r_line_addr  <= '0;
      r_chunk_addr <= '0;
      r_rd_addr    <= '0;
      r_rd_len     <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (w_go & w_zero) | (w_cmplt & start & w_frame_end);
      if (w_go) begin
        r_vres       <= vres;
        r_line       <= '0;
        r_line_bytes <= w_line_bytes;
        r_rem        <= w_line_bytes;
        r_line_addr  <= frame_base;
        r_chunk_addr <= frame_base;
      end
      if (r_state == S_ISSUE) begin
        r_rd_addr <= r_chunk_addr;
        r_rd_len  <= 16'(w_chunk_len);
      end
      if (w_cmplt) begin
        r_rem        <= r_rem - r_rd_len[12:0];
        r_chunk_addr <= r_chunk_addr + ADDR_W'(r_rd_len);
      end
      if (w_adv_line) begin
        r_line       <= r_line + 11'd1;
        r_line_addr  <= r_line_addr + ADDR_W'(r_line_bytes);
        r_chunk_addr <= r_line_addr + ADDR_W'(r_line_bytes);
        r_rem        <= r_line_bytes;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || w_go) begin
      r_pend_line  <= 1'b0;
      r_pend_chunk <= 1'b0;
      r_overrun    <= reset ? 1'b0 : 1'b0;
    end else if (w_in_burst && w_pulse) begin
      if (w_pend_any) begin
        r_overrun <= 1'b1;
      end else begin
        r_pend_line  <= read_next_line;
        r_pend_chunk <= read_next_chunk & ~read_next_line;
      end
    end else if (r_state == S_ARMED && w_pend_any) begin
      r_pend_line  <= read_next_line;
      r_pend_chunk <= read_next_chunk & ~read_next_line;
    end
  end

endmodule

// File: tb/tb_hdmi_read_scheduler.sv
// Self-checking bench for hdmi_read_scheduler: randomized frames against an arithmetic burst model.
module tb_hdmi_read_scheduler;
  localparam int unsigned CB = 256;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic        read_go = 1'b0, nl = 1'b0, nc = 1'b0;
  logic [31:0] frame_base = '0;
  logic [10:0] hres = '0, vres = '0;
  logic [1:0]  bpp = '0;
  logic        read_done, busy, overrun, timeout_err;
  int unsigned n_vec = 0, n_err = 0, done_cnt = 0, exp_done = 0;

  hdmi_read_scheduler_if #(.ADDR_W(32)) bus ();

  hdmi_read_scheduler #(.ADDR_W(32), .CHUNK_BYTES(CB), .TIMEOUT_CYCLES(16)) dut (
    .clock(clk), .reset(rst), .start(start), .frame_base(frame_base), .hres(hres), .vres(vres),
    .num_bytes_per_pixel(bpp), .read_go(read_go), .read_next_line(nl), .read_next_chunk(nc),
    .read_done(read_done), .busy(busy), .overrun(overrun), .timeout_err(timeout_err), .rd(bus)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (read_done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind 1 = next chunk, 2 = next line (optionally with a simultaneous chunk that must lose)
  task automatic drive_pulse(input int unsigned kind);
    if (kind == 1) nc = 1'b1;
    if (kind == 2) begin
      nl = 1'b1;
      nc = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic serve_burst(input logic [31:0] ea, input logic [31:0] el, input int unsigned ack_dly,
                             input int unsigned cmp_dly, input int unsigned pkind,
                             input int unsigned pat);
    int unsigned n = 0;
    while (bus.rd_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("req_seen", bus.rd_req, 1);
    chk("req_addr", bus.rd_addr, ea);
    chk("req_len", bus.rd_len, el);
    for (int unsigned i = 0; i < ack_dly; i++) begin
      tick();
      chk("hold_req", bus.rd_req, 1);
      chk("hold_addr", bus.rd_addr, ea);
      chk("hold_len", bus.rd_len, el);
    end
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    chk("req_drop", bus.rd_req, 0);
    for (int unsigned i = 0; i < cmp_dly; i++) begin
      if (pkind != 0 && i == pat) drive_pulse(pkind);
      tick();
      nl = 1'b0;
      nc = 1'b0;
    end
    bus.rd_cmplt = 1'b1;
    tick();
    bus.rd_cmplt = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] base, input int unsigned h, input int unsigned v,
                           input int unsigned b, input bit spur);
    int unsigned sh, lb, nch, kind, d0;
    bit          last, early;
    logic [31:0] ea, el;
    sh  = (b == 0) ? 0 : (b == 1) ? 1 : 2;
    lb  = h << sh;
    nch = (lb + CB - 1) / CB;
    d0  = done_cnt;
    frame_base = base; hres = 11'(h); vres = 11'(v); bpp = 2'(b); start = 1'b1;
    read_go = 1'b1;
    tick();
    read_go = 1'b0;
    chk("go_busy", busy, 1);
    chk("go_lat1", bus.rd_req, 0);
    tick();
    chk("go_lat2", bus.rd_req, 1);
    for (int unsigned l = 0; l < v; l++) begin
      for (int unsigned c = 0; c < nch; c++) begin
        int unsigned ad, cd;
        ea    = base + 32'(l * lb) + 32'(c * CB);
        el    = (c == nch - 1) ? 32'(lb - (nch - 1) * CB) : 32'(CB);
        last  = (l == v - 1) && (c == nch - 1);
        kind  = last ? 0 : (c < nch - 1) ? 1 : 2;
        early = !spur && ($urandom_range(0, 1) == 1);
        ad    = $urandom_range(0, 3);
        cd    = $urandom_range(1, 4);
        serve_burst(ea, el, ad, cd, early ? kind : 0, $urandom_range(0, cd - 1));
        if (last) begin
          chk("done_pulse", read_done, 1);
          chk("done_busy", busy, 0);
        end else begin
          chk("no_early_done", read_done, 0);
          if (early) begin
            chk("pend_lat0", bus.rd_req, 0);
            tick();
            chk("pend_lat1", bus.rd_req, 0);
            tick();
            chk("pend_lat2", bus.rd_req, 1);
          end else begin
            if (spur && (kind == 2 || l == v - 1)) begin
              if (kind == 2) nc = 1'b1; else nl = 1'b1;
              tick();
              nl = 1'b0; nc = 1'b0;
              tick();
              chk("spur_req", bus.rd_req, 0);
              chk("spur_busy", busy, 1);
              chk("spur_ovr", overrun, 0);
            end
            drive_pulse(kind);
            tick();
            nl = 1'b0; nc = 1'b0;
            chk("pulse_lat1", bus.rd_req, 0);
            tick();
            chk("pulse_lat2", bus.rd_req, 1);
          end
        end
      end
    end
    exp_done++;
    tick();
    chk("done_1cyc", read_done, 0);
    chk("frame_ovr", overrun, 0);
    chk("frame_done_cnt", done_cnt - d0, 1);
  endtask

  initial begin
    bus.rd_ack = 1'b0;
    bus.rd_cmplt = 1'b0;
    tick();
    tick();
    chk("rst_req", bus.rd_req, 0);
    chk("rst_addr", bus.rd_addr, 0);
    chk("rst_len", bus.rd_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", read_done, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_tmo", timeout_err, 0);
    rst = 1'b0;
    tick();

    run_frame(32'h1000_0000, 1280, 2, 2, 1'b0);
    run_frame(32'h0000_4000, 100, 3, 0, 1'b1);
    run_frame(32'h0800_0000, 70, 1, 2, 1'b1);
    for (int k = 0; k < 6; k++) begin
      logic [31:0] rb;
      rb = (k % 2 == 0) ? $urandom : (32'hFFFF_F800 + $urandom_range(0, 2047));
      run_frame(rb, $urandom_range(1, 400), $urandom_range(1, 3), $urandom_range(0, 3), 1'b0);
    end

    for (int z = 0; z < 2; z++) begin
      hres = (z == 0) ? 11'd0 : 11'd50;
      vres = (z == 0) ? 11'd4 : 11'd0;
      read_go = 1'b1;
      tick();
      read_go = 1'b0;
      exp_done++;
      chk("zero_done", read_done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_req", bus.rd_req, 0);
      tick();
      chk("zero_done_1cyc", read_done, 0);
    end

    frame_base = 32'h2000_0000; hres = 11'd1280; vres = 11'd1; bpp = 2'd2; start = 1'b1;
    read_go = 1'b1;
    tick();
    read_go = 1'b0;
    tick();
    chk("ov_req", bus.rd_req, 1);
    chk("ov_addr", bus.rd_addr, 32'h2000_0000);
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    nc = 1'b1;
    tick();
    nc = 1'b0;
    chk("ov_first", overrun, 0);
    nc = 1'b1;
    tick();
    nc = 1'b0;
    chk("ov_second", overrun, 1);
    bus.rd_cmplt = 1'b1;
    tick();
    bus.rd_cmplt = 1'b0;
    tick();
    tick();
    chk("ov_next_req", bus.rd_req, 1);
    chk("ov_next_addr", bus.rd_addr, 32'h2000_0100);
    chk("ov_next_len", bus.rd_len, 256);

    start = 1'b0;
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    chk("sl_busy", busy, 1);
    bus.rd_cmplt = 1'b1;
    tick();
    bus.rd_cmplt = 1'b0;
    chk("sl_idle", busy, 0);
    chk("sl_nodone", read_done, 0);
    chk("ov_sticky", overrun, 1);
    read_go = 1'b1;
    tick();
    read_go = 1'b0;
    chk("go_needs_start", busy, 0);

    start = 1'b1; frame_base = 32'h3000_0040; hres = 11'd16; bpp = 2'd0; vres = 11'd2;
    read_go = 1'b1;
    tick();
    read_go = 1'b0;
    chk("ov_clear", overrun, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_req", bus.rd_req, 1);
      chk("stall_addr", bus.rd_addr, 32'h3000_0040);
      chk("stall_len", bus.rd_len, 16);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("mid_rst_req", bus.rd_req, 0);
    chk("mid_rst_addr", bus.rd_addr, 0);
    chk("mid_rst_len", bus.rd_len, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", read_done, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_tmo", timeout_err, 0);
    rst = 1'b0;
    bus.rd_ack = 1'b1;
    bus.rd_cmplt = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    bus.rd_cmplt = 1'b0;
    tick();
    tick();
    chk("stray_busy", busy, 0);
    chk("stray_req", bus.rd_req, 0);
    chk("stray_done", read_done, 0);

    hres = 11'd16; vres = 11'd1; bpp = 2'd0;
    read_go = 1'b1;
    tick();
    read_go = 1'b0;
    tick();
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
`ifdef HDMI_RD_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("tmo_early", timeout_err, 0);
    end
    tick();
    chk("tmo_set", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    tick();
    tick();
    chk("tmo_nodone", read_done, 0);
    read_go = 1'b1;
    tick();
    read_go = 1'b0;
    chk("tmo_clear", timeout_err, 0);
`else
    for (int i = 0; i < 40; i++) tick();
    chk("no_tmo_flag", timeout_err, 0);
    chk("no_tmo_busy", busy, 1);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("done_total", done_cnt, exp_done);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
